// File: rtl/uart_tx_framed.sv
// Framed UART transmitter with a one-entry holding register, optional parity
// and one or two stop bits. tx, busy and tx_done are registered outputs.
module uart_tx_framed #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned WORD_WIDTH   = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IW = $clog2(WORD_WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(WORD_WIDTH - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [WORD_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_q, par_d;
    logic [WORD_WIDTH-1:0]   hold_data;
    logic                    hold_full;
    logic                    load;
    logic                    accept;
    logic                    tick;
    logic                    tx_d;
    logic                    done_d;
    logic                    busy_d;

    assign s_ready = ~hold_full;
    assign accept  = s_valid & ~hold_full;
    assign tick    = (cnt_q == CNT_MAX);

    // A new accept wins over the transfer so a word arriving on the same edge is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_data <= s_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx      <= tx_d;
            busy    <= busy_d;
            tx_done <= done_d;
        end
    end

    // Line outputs are computed from the current state and registered, so tx
    // trails the FSM by one cycle; busy and tx_done trail identically to stay aligned.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        load    = 1'b0;
        tx_d    = 1'b1;
        done_d  = 1'b0;
        busy_d  = (state_q != IDLE);

        if (state_q != IDLE)
            cnt_d = tick ? '0 : cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (hold_full) begin
                    load    = 1'b1;
                    state_d = START;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            PAR: begin
                tx_d = par_q;
                if (tick) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (idx_q == LAST_STOP) begin
                        done_d = 1'b1;
                        idx_d  = '0;
                        if (hold_full) begin
                            load    = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shift_d = hold_data;
            par_d   = (^hold_data) ^ (PARITY == 1);
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: four parameterisations share clk/rst_n,
// expected line bit sequences are hand-derived constants.
module tb_uart_tx_framed;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] da;
    logic [6:0] dd;
    logic       va, vb, vc, vd;
    logic       ra, rb, rc, rd;
    logic       ta, tb_, tc, td;
    logic       ba, bb, bc, bd;
    logic       oa, ob, oc, od;
    int         sel;
    logic       tx_s, busy_s, done_s, ready_s;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    uart_tx_framed #(.CLKS_PER_BIT(4), .WORD_WIDTH(8), .STOP_BITS(1), .PARITY(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_data(da), .s_valid(va), .s_ready(ra),
        .tx(ta), .busy(ba), .tx_done(oa));
    uart_tx_framed #(.CLKS_PER_BIT(4), .WORD_WIDTH(8), .STOP_BITS(1), .PARITY(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_data(da), .s_valid(vb), .s_ready(rb),
        .tx(tb_), .busy(bb), .tx_done(ob));
    uart_tx_framed #(.CLKS_PER_BIT(4), .WORD_WIDTH(8), .STOP_BITS(1), .PARITY(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .s_data(da), .s_valid(vc), .s_ready(rc),
        .tx(tc), .busy(bc), .tx_done(oc));
    uart_tx_framed #(.CLKS_PER_BIT(4), .WORD_WIDTH(7), .STOP_BITS(2), .PARITY(0)) dut_d (
        .clk(clk), .rst_n(rst_n), .s_data(dd), .s_valid(vd), .s_ready(rd),
        .tx(td), .busy(bd), .tx_done(od));

    always_comb begin
        case (sel)
            1:       begin tx_s = tb_; busy_s = bb; done_s = ob; ready_s = rb; end
            2:       begin tx_s = tc;  busy_s = bc; done_s = oc; ready_s = rc; end
            3:       begin tx_s = td;  busy_s = bd; done_s = od; ready_s = rd; end
            default: begin tx_s = ta;  busy_s = ba; done_s = oa; ready_s = ra; end
        endcase
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_valid(input logic v);
        va = (sel == 0) ? v : 1'b0;
        vb = (sel == 1) ? v : 1'b0;
        vc = (sel == 2) ? v : 1'b0;
        vd = (sel == 3) ? v : 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_tx"}, tx_s, 1'b1);
        chk({tag, "_busy"}, busy_s, 1'b0);
        chk({tag, "_done"}, done_s, 1'b0);
    endtask

    // Accept edge N, then the edge N+1 sample where tx must still be idle.
    task automatic send(input logic [7:0] d, input logic keep_valid, input logic [7:0] next_d);
        da = d;
        dd = d[6:0];
        set_valid(1'b1);
        step();
        chk("hold_full_ready", ready_s, 1'b0);
        if (keep_valid) begin
            da = next_d;
            dd = next_d[6:0];
        end else begin
            set_valid(1'b0);
        end
        step();
        chk("launch_tx_idle", tx_s, 1'b1);
        chk("launch_ready", ready_s, 1'b1);
    endtask

    // Sample n bits of 4 cycles each; frame[i] is the i-th bit on the line.
    task automatic run_frame(input logic [15:0] frame, input int n, input int ready_low_n);
        int k = 0;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                if (k == 0) set_valid(1'b0);
                chk("frame_tx", tx_s, frame[i]);
                chk("frame_busy", busy_s, 1'b1);
                chk("frame_done", done_s, (i == n - 1) && (c == 3));
                chk("frame_ready", ready_s, (k < ready_low_n) ? 1'b0 : 1'b1);
                k++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        da = 8'h00;
        dd = 7'h00;
        sel = 0;
        set_valid(1'b0);
        step();
        step();
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #0;
            check_idle("reset");
            chk("reset_ready", ready_s, 1'b1);
        end
        rst_n = 1'b1;
        step();

        // 0xA5, 8N1: 0 1 0 1 0 0 1 0 1 1
        sel = 0;
        send(8'hA5, 1'b0, 8'h00);
        run_frame(16'h034A, 10, 0);
        step();
        check_idle("a5_after");

        // 0x07 even parity -> parity 1
        sel = 1;
        send(8'h07, 1'b0, 8'h00);
        run_frame(16'h060E, 11, 0);
        step();
        check_idle("even_after");

        // 0x07 odd parity -> parity 0
        sel = 2;
        send(8'h07, 1'b0, 8'h00);
        run_frame(16'h040E, 11, 0);
        step();
        check_idle("odd_after");

        // 7 data bits 0x55, two stop bits
        sel = 3;
        send(8'h55, 1'b0, 8'h00);
        run_frame(16'h03AA, 10, 0);
        step();
        check_idle("w7s2_after");

        // Back-to-back 0x00 then 0xFF with s_valid held
        sel = 0;
        send(8'h00, 1'b1, 8'hFF);
        run_frame(16'h0200, 10, 39);
        run_frame(16'h03FE, 10, 0);
        step();
        check_idle("b2b_after");

        // Idle line with s_data toggling and s_valid low
        set_valid(1'b0);
        for (int i = 0; i < 100; i++) begin
            da = 8'(i * 37 + 5);
            step();
            check_idle("noval");
            chk("noval_ready", ready_s, 1'b1);
        end

        // Reset mid-frame with a word pending
        send(8'h3C, 1'b0, 8'h00);
        da = 8'h11;
        set_valid(1'b1);
        for (int i = 0; i < 10; i++) begin
            step();
            set_valid(1'b0);
            chk("midframe_busy", busy_s, 1'b1);
        end
        chk("pending_ready", ready_s, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx", tx_s, 1'b1);
        chk("rst_async_ready", ready_s, 1'b1);
        chk("rst_async_busy", busy_s, 1'b0);
        chk("rst_async_done", done_s, 1'b0);
        step();
        check_idle("rst_held");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("post_rst");
        end
        // 0x81: 0 1 0 0 0 0 0 0 1 1
        send(8'h81, 1'b0, 8'h00);
        run_frame(16'h0302, 10, 0);
        step();
        check_idle("post_rst_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
